// File: rtl/operand_mux_arbiter_if.sv
// Operand request/response bundle shared by the two requesters and the mux arbiter.
// The master side drives requests and operands; the slave side drives acks and the captured result.
interface operand_mux_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_a;
  logic             ack_b;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             busy;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  ack_a, ack_b, sel, y, y_valid, busy
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output ack_a, ack_b, sel, y, y_valid, busy
  );
endinterface

// File: rtl/operand_mux_arbiter.sv
// Round-robin arbiter for the shared 2:1 operand mux. It holds sel for HOLD_CYCLES edges,
// then registers the selected operand and acks the requester with a 4-phase handshake.
module operand_mux_arbiter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_mux_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StGrantA, StGrantB, StWaitA, StWaitB} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             last_b_q;
  logic             served_q;
  logic             sel_q;
  logic             ack_a_q;
  logic             ack_b_q;
  logic             y_valid_q;
  logic [WIDTH-1:0] y_q;

  logic own_b;
  logic own_req;
  logic pick_b;

  assign own_b   = (state_q == StGrantB) || (state_q == StWaitB);
  assign own_req = own_b ? bus.req_b : bus.req_a;
  // served_q separates "nothing served since reset" (A wins) from "A was served last" (B wins).
  assign pick_b  = bus.req_b && (!bus.req_a || (served_q && !last_b_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_b_q  <= 1'b0;
      served_q  <= 1'b0;
      sel_q     <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          y_valid_q <= 1'b0;
          if (bus.req_a || bus.req_b) begin
            state_q <= pick_b ? StGrantB : StGrantA;
            sel_q   <= pick_b;
            cnt_q   <= CntLoad;
          end
        end
        StGrantA, StGrantB: begin
          // A dropped request abandons the grant without touching y or the round-robin order.
          if (!own_req) begin
            state_q <= StIdle;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            y_q       <= own_b ? bus.data_b : bus.data_a;
            y_valid_q <= 1'b1;
            ack_a_q   <= !own_b;
            ack_b_q   <= own_b;
            state_q   <= own_b ? StWaitB : StWaitA;
          end
        end
        StWaitA, StWaitB: begin
          y_valid_q <= 1'b0;
          if (!own_req) begin
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            last_b_q <= own_b;
            served_q <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.ack_a   = ack_a_q;
  assign bus.ack_b   = ack_b_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_operand_mux_arbiter.sv
// Bench for operand_mux_arbiter: HOLD_CYCLES=1 and =3 instances share one stimulus stream and
// are checked every cycle against a transaction-level model, plus hand-computed directed checks.
module tb_operand_mux_arbiter;
  localparam int unsigned W     = 4;
  localparam int unsigned HoldA = 1;
  localparam int unsigned HoldB = 3;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         req_a  = 1'b0;
  logic         req_b  = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_mux_arbiter_if #(.WIDTH(W)) bus1 ();
  operand_mux_arbiter_if #(.WIDTH(W)) bus3 ();

  assign bus1.req_a  = req_a;
  assign bus1.req_b  = req_b;
  assign bus1.data_a = data_a;
  assign bus1.data_b = data_b;
  assign bus3.req_a  = req_a;
  assign bus3.req_b  = req_b;
  assign bus3.data_a = data_a;
  assign bus3.data_b = data_b;

  operand_mux_arbiter #(.WIDTH(W), .HOLD_CYCLES(HoldA)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  operand_mux_arbiter #(.WIDTH(W), .HOLD_CYCLES(HoldB)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  logic [W-1:0] d_y     [2];
  logic         d_yv    [2];
  logic         d_ack_a [2];
  logic         d_ack_b [2];
  logic         d_sel   [2];
  logic         d_busy  [2];

  assign d_y[0]     = bus1.y;
  assign d_y[1]     = bus3.y;
  assign d_yv[0]    = bus1.y_valid;
  assign d_yv[1]    = bus3.y_valid;
  assign d_ack_a[0] = bus1.ack_a;
  assign d_ack_a[1] = bus3.ack_a;
  assign d_ack_b[0] = bus1.ack_b;
  assign d_ack_b[1] = bus3.ack_b;
  assign d_sel[0]   = bus1.sel;
  assign d_sel[1]   = bus3.sel;
  assign d_busy[0]  = bus1.busy;
  assign d_busy[1]  = bus3.busy;

  // Model: owner 0 = nobody, 1 = A, 2 = B; age counts edges since the grant.
  int           hold_of [2];
  int           m_owner [2];
  int           m_age   [2];
  bit           m_hold  [2];
  bit           m_first [2];
  bit           m_lastb [2];
  logic [W-1:0] m_y     [2];
  bit           m_yv    [2];
  bit           m_ack_a [2];
  bit           m_ack_b [2];
  bit           m_sel   [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0;
      m_age[i]   = 0;
      m_hold[i]  = 1'b0;
      m_first[i] = 1'b1;
      m_lastb[i] = 1'b0;
      m_y[i]     = '0;
      m_yv[i]    = 1'b0;
      m_ack_a[i] = 1'b0;
      m_ack_b[i] = 1'b0;
      m_sel[i]   = 1'b0;
    end
  endtask

  task automatic model_step();
    bit r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m_yv[i] = 1'b0;
      if (m_owner[i] == 0) begin
        if (req_a || req_b) begin
          m_owner[i] = (req_a && !(req_b && !m_first[i] && !m_lastb[i])) ? 1 : 2;
          m_age[i]   = 0;
          m_sel[i]   = (m_owner[i] == 2);
        end
      end else begin
        r = (m_owner[i] == 1) ? req_a : req_b;
        if (m_hold[i]) begin
          if (!r) begin
            m_ack_a[i] = 1'b0;
            m_ack_b[i] = 1'b0;
            m_lastb[i] = (m_owner[i] == 2);
            m_first[i] = 1'b0;
            m_owner[i] = 0;
            m_hold[i]  = 1'b0;
          end
        end else if (!r) begin
          m_owner[i] = 0;
        end else begin
          m_age[i]++;
          if (m_age[i] == hold_of[i]) begin
            m_y[i]     = (m_owner[i] == 1) ? data_a : data_b;
            m_yv[i]    = 1'b1;
            m_hold[i]  = 1'b1;
            m_ack_a[i] = (m_owner[i] == 1);
            m_ack_b[i] = (m_owner[i] == 2);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    string p;
    for (int i = 0; i < 2; i++) begin
      p = $sformatf("h%0d_", hold_of[i]);
      check({p, "y"},       int'(d_y[i]),     int'(m_y[i]));
      check({p, "y_valid"}, int'(d_yv[i]),    int'(m_yv[i]));
      check({p, "ack_a"},   int'(d_ack_a[i]), int'(m_ack_a[i]));
      check({p, "ack_b"},   int'(d_ack_b[i]), int'(m_ack_b[i]));
      check({p, "sel"},     int'(d_sel[i]),   int'(m_sel[i]));
      check({p, "busy"},    int'(d_busy[i]),  int'(m_owner[i] != 0));
      check({p, "ack_excl"}, int'(d_ack_a[i] && d_ack_b[i]), 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
  endtask

  initial begin
    hold_of[0] = HoldA;
    hold_of[1] = HoldB;
    if (HoldA < 1 || HoldB < 1) begin
      $display("FAIL hold_cycles: HOLD_CYCLES must be >= 1");
      $fatal(1);
    end
    model_reset();
    repeat (2) step();
    check("rst_y",     int'(d_y[0]),     0);
    check("rst_busy",  int'(d_busy[1]),  0);
    check("rst_sel",   int'(d_sel[0]),   0);
    check("rst_ack_a", int'(d_ack_a[1]), 0);
    rst_n = 1'b1;
    step();

    // Single A request, data 5
    req_a = 1'b1; data_a = 4'd5;
    step();
    check("t2_sel", int'(d_sel[0]), 0);
    check("t2_busy", int'(d_busy[0]), 1);
    check("t2_yv_early", int'(d_yv[0]), 0);
    step();
    check("t2_y", int'(d_y[0]), 5);
    check("t2_yv", int'(d_yv[0]), 1);
    check("t2_ack_a", int'(d_ack_a[0]), 1);
    check("h3_yv_early", int'(d_yv[1]), 0);
    step();
    check("t2_yv_pulse", int'(d_yv[0]), 0);
    check("t2_ack_hold", int'(d_ack_a[0]), 1);
    step();
    check("h3_y", int'(d_y[1]), 5);
    check("h3_yv", int'(d_yv[1]), 1);
    req_a = 1'b0;
    step();
    check("t2_ack_drop", int'(d_ack_a[0]), 0);

    // Async reset while B is granted
    req_b = 1'b1; data_b = 4'd9;
    step();
    check("t1_sel_b", int'(d_sel[0]), 1);
    req_b = 1'b0;
    async_reset();
    check("t1_y", int'(d_y[0]), 0);
    check("t1_sel", int'(d_sel[0]), 0);
    check("t1_busy", int'(d_busy[1]), 0);
    check("t1_sel3", int'(d_sel[1]), 0);
    step();
    rst_n = 1'b1;

    // Contention straight after reset: A first, then B
    req_a = 1'b1; data_a = 4'd14; req_b = 1'b1; data_b = 4'd15;
    step();
    check("t3_sel_a", int'(d_sel[0]), 0);
    step();
    check("t3_y_a", int'(d_y[0]), 14);
    check("t3_ack_a", int'(d_ack_a[0]), 1);
    check("t3_ack_b_low", int'(d_ack_b[0]), 0);
    step();
    step();
    check("t3_h3_y_a", int'(d_y[1]), 14);
    req_a = 1'b0;
    step();
    req_a = 1'b1;
    step();
    check("t3_sel_b", int'(d_sel[0]), 1);
    check("t3_sel_b3", int'(d_sel[1]), 1);
    step();
    check("t3_y_b", int'(d_y[0]), 15);
    check("t3_ack_b", int'(d_ack_b[0]), 1);
    check("t3_ack_a_low", int'(d_ack_a[0]), 0);
    step();
    step();
    check("t3_h3_y_b", int'(d_y[1]), 15);
    req_b = 1'b0;
    step();
    repeat (4) step();
    req_a = 1'b0;
    step();

    // Abort a B grant with HOLD=3; the next contention grants B again
    req_a = 1'b1; req_b = 1'b1; data_a = 4'd6; data_b = 4'd3;
    step();
    check("t4_sel_b", int'(d_sel[1]), 1);
    req_a = 1'b0; req_b = 1'b0;
    step();
    check("t4_y_kept", int'(d_y[1]), 14);
    check("t4_no_yv", int'(d_yv[1]), 0);
    check("t4_no_ack", int'(d_ack_b[1]), 0);
    check("t4_idle", int'(d_busy[1]), 0);
    req_a = 1'b1; req_b = 1'b1;
    step();
    check("t4_regrant_sel", int'(d_sel[1]), 1);
    check("t4_regrant_busy", int'(d_busy[1]), 1);
    repeat (3) step();
    check("t4_y_b", int'(d_y[1]), 3);
    check("t4_ack_b", int'(d_ack_b[1]), 1);
    req_a = 1'b0; req_b = 1'b0;
    step();

    // HOLD=3 latency, then data change during WAIT_A
    req_a = 1'b1; data_a = 4'd7;
    step();
    check("t5_sel", int'(d_sel[1]), 0);
    check("t5_busy", int'(d_busy[1]), 1);
    step();
    check("t5_hold1_yv", int'(d_yv[1]), 0);
    check("t5_hold1_y", int'(d_y[1]), 3);
    step();
    check("t5_hold2_yv", int'(d_yv[1]), 0);
    step();
    check("t5_y", int'(d_y[1]), 7);
    check("t5_yv", int'(d_yv[1]), 1);
    data_a = 4'd2;
    step();
    check("t6_y", int'(d_y[1]), 7);
    check("t6_no_yv", int'(d_yv[1]), 0);
    check("t6_ack_a", int'(d_ack_a[1]), 1);
    req_a = 1'b0;
    step();

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if (!req_a) begin
        if ($urandom_range(2) == 0) begin
          req_a  = 1'b1;
          data_a = W'($urandom);
        end
      end else if ($urandom_range(5) == 0) begin
        req_a = 1'b0;
      end
      if (!req_b) begin
        if ($urandom_range(2) == 0) begin
          req_b  = 1'b1;
          data_b = W'($urandom);
        end
      end else if ($urandom_range(5) == 0) begin
        req_b = 1'b0;
      end
      if ($urandom_range(299) == 0) begin
        async_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
